mul_unit: RTL and testbench

Sequential signed N×N shift-add multiplier on the execute path of the pico MIPS core. It consumes the two operands read from the register file (Rs_data, and Rt_data or an immediate selected upstream) and returns one N-bit result together with a one-cycle write-enable and destination address. These connect directly to the register file's Wdata / w_enable / Rd inputs. The result is either the integer low half or the Q1.(N-1) fractional high half of the product, with saturation. The control FSM stalls the core while busy is high.

---
 rtl/mul_unit.sv | 147 ++++++++++++++
 tb/tb_mul_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// mul_unit: sequential signed NxN shift-add multiplier for the pico MIPS
// execute path. Each op takes N cycles from acceptance to the done pulse.
//
// Ports:
//   clk     - system clock, rising edge
//   n_reset - asynchronous active-low reset
//   start   - op request, sampled only while busy is low
//   frac    - 0: integer result (low N bits, wraps)
//             1: Q1.(N-1) result (high half, saturating)
//   a, b    - signed operands
//   rd_in   - destination register for the op
//   busy    - op in progress (core stalls)
//   done    - one-cycle completion pulse (register file write enable)
//   rd_out  - latched destination (register file Rd)
//   result  - product, held until the next completion (register file Wdata)
//
// Optional feature: define MUL_ROUND_EN to round fractional results half up
// instead of truncating them.
module mul_unit #(
  parameter int N = 8,
  parameter int M = 32
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic                 frac,
  input  logic [N-1:0]         a,
  input  logic [N-1:0]         b,
  input  logic [$clog2(M)-1:0] rd_in,
  output logic                 busy,
  output logic                 done,
  output logic [$clog2(M)-1:0] rd_out,
  output logic [N-1:0]         result
);

  localparam int RW = $clog2(M);
  localparam int CW = $clog2(N);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic            state_reg;
  logic            frac_reg;
  logic            sign_reg;
  logic [N-1:0]    mag_a_reg;
  logic [N-1:0]    mag_b_reg;
  logic [2*N-1:0]  acc_reg;
  logic [CW-1:0]   count_reg;
  logic            done_reg;
  logic [RW-1:0]   rd_reg;
  logic [N-1:0]    result_reg;

  // Magnitudes of the incoming operands; -(-2^(N-1)) wraps back to
  // 2^(N-1), which is exactly right when read as unsigned.
  logic [N-1:0]    mag_a_in;
  logic [N-1:0]    mag_b_in;
  assign mag_a_in = a[N-1] ? -a : a;
  assign mag_b_in = b[N-1] ? -b : b;

  // One shift-add step; on the last RUN edge acc_next is the full
  // unsigned product, so the final step folds straight into the result.
  logic [2*N-1:0]  addend;
  logic [2*N-1:0]  acc_next;
  logic [2*N-1:0]  prod;
  logic            last_step;

  assign addend    = mag_b_reg[count_reg] ? ({{N{1'b0}}, mag_a_reg} << count_reg) : '0;
  assign acc_next  = acc_reg + addend;
  assign prod      = sign_reg ? -acc_next : acc_next;
  assign last_step = (count_reg == CW'(N - 1));

  // Fractional path: optional round-half-up ahead of the bit selection.
  logic [2*N-1:0]  prod_frac;
`ifdef MUL_ROUND_EN
  localparam logic [2*N-1:0] ROUND_HALF = {{(N+1){1'b0}}, 1'b1, {(N-2){1'b0}}};
  assign prod_frac = prod + ROUND_HALF;
`else
  assign prod_frac = prod;
`endif

  // prod_frac >= 2^(2N-2): only reachable from (-2^(N-1))^2 (plus rounding).
  logic            frac_sat;
  logic [N-1:0]    result_next;
  assign frac_sat = ~prod_frac[2*N-1] & prod_frac[2*N-2];

  always_comb begin
    result_next = prod[N-1:0];
    if (frac_reg) begin
      if (frac_sat) begin
        result_next = {1'b0, {(N-1){1'b1}}};
      end else begin
        result_next = prod_frac[2*N-2:N-1];
      end
    end
  end

  // Fraction bits below the selected window are intentionally dropped.
  logic unused_frac_bits;
  assign unused_frac_bits = ^prod_frac[N-2:0];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg  <= IDLE;
      frac_reg   <= 1'b0;
      sign_reg   <= 1'b0;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      done_reg   <= 1'b0;
      rd_reg     <= '0;
      result_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            frac_reg  <= frac;
            rd_reg    <= rd_in;
            sign_reg  <= a[N-1] ^ b[N-1];
            mag_a_reg <= mag_a_in;
            mag_b_reg <= mag_b_in;
            acc_reg   <= '0;
            count_reg <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + CW'(1);
          if (last_step) begin
            result_reg <= result_next;
            done_reg   <= 1'b1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = done_reg;
  assign rd_out = rd_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: randomized scoreboard bench for mul_unit (N = 8, M = 32).
// Expected results come from integer arithmetic on the operand values;
// acceptance and timing come from a simple count-down busy model.
module tb_mul_unit;

  localparam int N  = 8;
  localparam int M  = 32;
  localparam int RW = $clog2(M);

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          start = 1'b0;
  logic          frac = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic [RW-1:0] rd_in = '0;
  logic          busy;
  logic          done;
  logic [RW-1:0] rd_out;
  logic [N-1:0]  result;

  mul_unit #(.N(N), .M(M)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start),
    .frac    (frac),
    .a       (a),
    .b       (b),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .rd_out  (rd_out),
    .result  (result)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Scoreboard entries: {expected result, expected rd}.
  logic [N+RW-1:0] exp_q[$];
  int              left = 0;
  bit              mdl_done = 1'b0;
  logic [N-1:0]    held_exp = '0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference: plain signed arithmetic on the operand values.
  function automatic logic [N-1:0] ref_mul(logic [N-1:0] av, logic [N-1:0] bv, bit fr);
    int p;
    int q;
    p = int'($signed(av)) * int'($signed(bv));
    if (!fr) return p[N-1:0];
`ifdef MUL_ROUND_EN
    p = p + (1 << (N - 2));
`endif
    q = p >>> (N - 1);
    if (q > (1 << (N - 1)) - 1) q = (1 << (N - 1)) - 1;
    return q[N-1:0];
  endfunction

  // Acceptance/timing model: an op is accepted when idle, busy for N edges.
  always @(posedge clk) begin
    if (!n_reset) begin
      left = 0;
      mdl_done = 1'b0;
      exp_q.delete();
    end else begin
      mdl_done = 1'b0;
      if (left == 0) begin
        if (start) begin
          exp_q.push_back({ref_mul(a, b, frac), rd_in});
          left = N;
        end
      end else begin
        left--;
        if (left == 0) mdl_done = 1'b1;
      end
    end
  end

  // Monitor: sample outputs on the falling edge, pop on every done.
  always @(negedge clk) begin
    logic [N+RW-1:0] e;
    if (!n_reset) begin
      held_exp = '0;
    end else begin
      check("busy", busy, left > 0);
      check("done", done, mdl_done);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          held_exp = e[N+RW-1:RW];
          check("result", result, e[N+RW-1:RW]);
          check("rd_out", rd_out, e[RW-1:0]);
          $display("op done: rd=%0d result=%02h expected %02h/%0d", rd_out, result, e[N+RW-1:RW], e[RW-1:0]);
        end
      end
      check("result_held", result, held_exp);
    end
  end

  task automatic drive(bit s, logic [N-1:0] aa, logic [N-1:0] bb, bit f, logic [RW-1:0] r);
    @(negedge clk);
    #1;
    start = s;
    a     = aa;
    b     = bb;
    frac  = f;
    rd_in = r;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) drive(1'b0, N'($urandom), N'($urandom), 1'($urandom), RW'($urandom));
  endtask

  task automatic one_op(logic [N-1:0] aa, logic [N-1:0] bb, bit f, logic [RW-1:0] r);
    drive(1'b1, aa, bb, f, r);
    idle_cycles(N + 2);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_result"}, result, '0);
    check({tag, "_rd_out"}, rd_out, '0);
  endtask

  logic [N-1:0] edge_vals[4] = '{8'h80, 8'h7F, 8'h00, 8'hFF};

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    #1;
    n_reset = 1'b1;

    // Directed cases.
    one_op(8'h03, 8'h05, 1'b0, 5'd7);
    one_op(8'hFD, 8'h07, 1'b0, 5'd12);
    one_op(8'h40, 8'h40, 1'b1, 5'd3);
    one_op(8'h80, 8'h80, 1'b1, 5'd31);
    one_op(8'h01, 8'h40, 1'b1, 5'd1);
    one_op(8'hFF, 8'h40, 1'b1, 5'd2);
    one_op(8'h80, 8'h80, 1'b0, 5'd4);
    one_op(8'h00, 8'h00, 1'b0, 5'd5);

    // Start held high with operands changing every cycle: one op per N+1.
    for (int i = 0; i < 4 * (N + 1); i++)
      drive(1'b1, N'($urandom), N'($urandom), 1'($urandom), RW'($urandom));
    idle_cycles(N + 2);

    // Reset in the middle of a run, then a normal op.
    drive(1'b1, 8'h55, 8'h33, 1'b0, 5'd9);
    idle_cycles(4);
    @(negedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    #1;
    n_reset = 1'b1;
    one_op(8'h12, 8'hF4, 1'b0, 5'd10);

    // Random traffic with sparse start and corner operands mixed in.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = N'($urandom);
      rb = N'($urandom);
      if ($urandom_range(0, 5) == 0) ra = edge_vals[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) rb = edge_vals[$urandom_range(0, 3)];
      drive($urandom_range(0, 2) == 0, ra, rb, 1'($urandom), RW'($urandom));
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 4 * N && left > 0; i++) idle_cycles(1);
    idle_cycles(2);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
